// File: rtl/spi_master_arbiter_pkg.sv
// rtl/spi_master_arbiter_pkg.sv - shared FSM encodings and defaults for the SPI master arbiter
package spi_master_arbiter_pkg;

    localparam int BUSY_TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DONE      = 3'd4
    } arb_state_t;

endpackage

// File: rtl/spi_rr_pick.sv
// rtl/spi_rr_pick.sv - combinational round-robin picker, search starts just after last owner
module spi_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic             any,
    output logic [IW-1:0]    idx
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    int                 pos;

    always_comb begin
        dbl = {req, req} >> (int'(last) + 1);
        rot = dbl[N_REQ-1:0];
        any = |req;
        idx = '0;
        pos = 0;
        // Descending scan so the lowest rotated position (highest priority) wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = int'(last) + 1 + i;
                if (pos >= N_REQ) begin
                    pos = pos - N_REQ;
                end
                idx = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - round-robin sequencer sharing one SPI master driver between requesters
module spi_master_arbiter
    import spi_master_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              done,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic                          busy,
    output logic [$clog2(N_REQ)-1:0]      grant_id,
    output logic                          spi_start,
    output logic [DATA_WIDTH-1:0]         spi_data_in,
    input  logic [DATA_WIDTH-1:0]         spi_data_out,
    input  logic                          spi_ready
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    arb_state_t       state;
    logic [IW-1:0]    last;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic [CW-1:0]    cnt;
    logic [N_REQ-1:0] grant_onehot;

    assign grant_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;

    spi_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req  (req),
        .last (last),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            last        <= IW'(N_REQ - 1);
            cnt         <= '0;
            done        <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= '0;
            spi_start   <= 1'b0;
            spi_data_in <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any && spi_ready) begin
                        grant_id    <= pick_idx;
                        spi_data_in <= req_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                        spi_start   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_START;
                    end
                end
                ST_START: begin
                    spi_start <= 1'b0;
                    cnt       <= '0;
                    state     <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    // Driver acceptance wins over a timeout landing in the same cycle.
                    if (!spi_ready) begin
                        state <= ST_WAIT_DONE;
                    end else if (cnt == CW'(BUSY_TIMEOUT)) begin
                        done    <= grant_onehot;
                        rsp_err <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (spi_ready) begin
                        rsp_data <= spi_data_out;
                        rsp_err  <= 1'b0;
                        done     <= grant_onehot;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= '0;
                    rsp_err <= 1'b0;
                    busy    <= 1'b0;
                    last    <= grant_id;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
